// File: rtl/regfile_arb_pkg.sv
// Shared types and sizes for the register-file write arbiter.
// Used by regfile_arb_fifo and regfile_write_arbiter.
package regfile_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_arb_fifo.sv
// Small synchronous FIFO for long-latency write requests, with full/empty flags.
// The head entry is presented combinationally and is dequeued with pop_i.
module regfile_arb_fifo
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  wr_req_t push_data_i,
  input  logic    pop_i,
  output wr_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  // The extra MSB on each pointer separates the full and empty cases.
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
  wr_req_t        mem_q [DEPTH];

  logic do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are valid, so stale data is never observed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter with long-latency result FIFO and pending scoreboard.
// Optional head-starvation stall is enabled by defining REGFILE_ARB_STARVE_EN.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iPipeWriteEn,
  input  logic [REG_ADDR_W-1:0] iPipeWriteAddr,
  input  logic [REG_DATA_W-1:0] iPipeWriteData,
  input  logic                  iLongIssue,
  input  logic [REG_ADDR_W-1:0] iLongIssueAddr,
  input  logic                  iLongValid,
  input  logic [REG_ADDR_W-1:0] iLongAddr,
  input  logic [REG_DATA_W-1:0] iLongData,
  output logic                  oLongReady,
  input  logic                  iSrc0En,
  input  logic [REG_ADDR_W-1:0] iSrc0Addr,
  input  logic                  iSrc1En,
  input  logic [REG_ADDR_W-1:0] iSrc1Addr,
  input  logic                  iDestEn,
  input  logic [REG_ADDR_W-1:0] iDestAddr,
  output logic                  oStall,
  output logic                  oWriteEn,
  output logic [REG_ADDR_W-1:0] oWriteAddr,
  output logic [REG_DATA_W-1:0] oWriteData,
  output logic                  oBusy
);

  if (DEPTH < 2 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("regfile_write_arbiter: DEPTH must be >= 2 and STARVE_LIMIT >= 1");
  end

  logic                  run_q;
  logic                  wen_q, wen_d;
  logic                  wlong_q, wlong_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [REG_DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_COUNT-1:0]  pending_q, pending_d;
  logic [REG_COUNT-1:0]  set_mask, clr_mask;

  wr_req_t fifo_in, fifo_head;
  logic    fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic    pipe_win, hazard, starve;

  // run_q holds ready low while reset is applied and for the release cycle.
  assign oLongReady = run_q & ~fifo_full;
  assign fifo_push  = iLongValid & oLongReady & (iLongAddr != '0);
  assign fifo_in    = '{addr: iLongAddr, data: iLongData};
  assign pipe_win   = iPipeWriteEn & (iPipeWriteAddr != '0);
  assign fifo_pop   = ~pipe_win & ~fifo_empty;

  regfile_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (iClk),
    .rst_i       (iRst),
    .push_i      (fifo_push),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign hazard = (iSrc0En & pending_q[iSrc0Addr]) |
                  (iSrc1En & pending_q[iSrc1Addr]) |
                  (iDestEn & pending_q[iDestAddr]);
  assign oStall = hazard | starve;
  assign oBusy  = (|pending_q) | ~fifo_empty;

`ifdef REGFILE_ARB_STARVE_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_LIMIT[STARVE_W-1:0];

  logic [STARVE_W-1:0] starve_cnt_q;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      starve_cnt_q <= '0;
    end else if (fifo_empty || fifo_pop) begin
      starve_cnt_q <= '0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  assign starve = (starve_cnt_q == STARVE_MAX);
`else
  assign starve = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    wen_d   = 1'b0;
    wlong_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pipe_win) begin
      wen_d   = 1'b1;
      waddr_d = iPipeWriteAddr;
      wdata_d = iPipeWriteData;
    end else if (!fifo_empty) begin
      wen_d   = 1'b1;
      wlong_d = 1'b1;
      waddr_d = fifo_head.addr;
      wdata_d = fifo_head.data;
    end
  end

  // A new issue wins over a clear of the same register in the same cycle.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (wen_q && wlong_q)        clr_mask[waddr_q]        = 1'b1;
    if (iLongIssue && !oStall)   set_mask[iLongIssueAddr] = 1'b1;
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      run_q     <= 1'b0;
      wen_q     <= 1'b0;
      wlong_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      run_q     <= 1'b1;
      wen_q     <= wen_d;
      wlong_q   <= wlong_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign oWriteEn   = wen_q;
  assign oWriteAddr = waddr_q;
  assign oWriteData = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus queues expected writes,
// a negedge monitor compares them; interlock/ready/busy checked inline.
module tb_regfile_write_arbiter;

`ifdef REGFILE_ARB_STARVE_EN
  localparam logic STARVE_ON = 1'b1;
`else
  localparam logic STARVE_ON = 1'b0;
`endif

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iPipeWriteEn;
  logic [4:0]  iPipeWriteAddr;
  logic [31:0] iPipeWriteData;
  logic        iLongIssue;
  logic [4:0]  iLongIssueAddr;
  logic        iLongValid;
  logic [4:0]  iLongAddr;
  logic [31:0] iLongData;
  logic        oLongReady;
  logic        iSrc0En, iSrc1En, iDestEn;
  logic [4:0]  iSrc0Addr, iSrc1Addr, iDestAddr;
  logic        oStall;
  logic        oWriteEn;
  logic [4:0]  oWriteAddr;
  logic [31:0] oWriteData;
  logic        oBusy;

  regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
    .iClk           (iClk),
    .iRst           (iRst),
    .iPipeWriteEn   (iPipeWriteEn),
    .iPipeWriteAddr (iPipeWriteAddr),
    .iPipeWriteData (iPipeWriteData),
    .iLongIssue     (iLongIssue),
    .iLongIssueAddr (iLongIssueAddr),
    .iLongValid     (iLongValid),
    .iLongAddr      (iLongAddr),
    .iLongData      (iLongData),
    .oLongReady     (oLongReady),
    .iSrc0En        (iSrc0En),
    .iSrc0Addr      (iSrc0Addr),
    .iSrc1En        (iSrc1En),
    .iSrc1Addr      (iSrc1Addr),
    .iDestEn        (iDestEn),
    .iDestAddr      (iDestAddr),
    .oStall         (oStall),
    .oWriteEn       (oWriteEn),
    .oWriteAddr     (oWriteAddr),
    .oWriteData     (oWriteData),
    .oBusy          (oBusy)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_write(input int c, input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{cyc: c, addr: a, data: d});
  endtask

  task automatic next();
    @(posedge iClk);
    #1;
  endtask

  task automatic idle();
    iPipeWriteEn = 0; iPipeWriteAddr = 0; iPipeWriteData = 0;
    iLongIssue = 0; iLongIssueAddr = 0;
    iLongValid = 0; iLongAddr = 0; iLongData = 0;
    iSrc0En = 0; iSrc0Addr = 0; iSrc1En = 0; iSrc1Addr = 0;
    iDestEn = 0; iDestAddr = 0;
  endtask

  // Monitor: every write-port cycle must match the head of the expected queue.
  always @(negedge iClk) begin
    if (iRst === 1'b0) begin
      if (oWriteEn) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write (cycle %0d)",
                   oWriteAddr, oWriteData, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", {27'b0, oWriteAddr}, {27'b0, mon_e.addr});
          check("write_data", oWriteData, mon_e.data);
          check("write_cycle", cyc, mon_e.cyc);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_write: got no write, expected addr %0d data 0x%08h at cycle %0d (now %0d)",
                 mon_e.addr, mon_e.data, mon_e.cyc, cyc);
      end
    end
  end

  initial begin
    idle();
    iRst = 1;
    repeat (2) next();
    check("rst_wen",   {31'b0, oWriteEn},   0);
    check("rst_waddr", {27'b0, oWriteAddr}, 0);
    check("rst_wdata", oWriteData,          0);
    check("rst_stall", {31'b0, oStall},     0);
    check("rst_busy",  {31'b0, oBusy},      0);
    check("rst_ready", {31'b0, oLongReady}, 0);
    iRst = 0;
    next();
    check("ready_after_release", {31'b0, oLongReady}, 1);
    next();

    // Pipeline write r5, then a dropped write to r0.
    iPipeWriteEn = 1; iPipeWriteAddr = 5; iPipeWriteData = 32'hAA;
    expect_write(cyc + 1, 5, 32'hAA);
    next();
    iPipeWriteAddr = 0; iPipeWriteData = 32'hFF;
    next();
    idle(); #1;
    check("r0_write_dropped", {31'b0, oWriteEn}, 0);
    repeat (2) next();

    // Long op to r7: RAW stall until its write cycle ends; same-cycle reissue blocked.
    iLongIssue = 1; iLongIssueAddr = 7;
    next();
    idle(); iSrc0En = 1; iSrc0Addr = 7; #1;
    check("stall_r7_pending", {31'b0, oStall}, 1);
    check("busy_r7_pending",  {31'b0, oBusy},  1);
    iSrc0Addr = 8; #1;
    check("no_stall_r8", {31'b0, oStall}, 0);
    next();
    iSrc0Addr = 7; iLongValid = 1; iLongAddr = 7; iLongData = 32'h77;
    expect_write(cyc + 2, 7, 32'h77);
    #1;
    check("ready_fifo_empty", {31'b0, oLongReady}, 1);
    check("stall_r7_accept",  {31'b0, oStall},     1);
    next();
    iLongValid = 0; #1;
    check("stall_r7_queued", {31'b0, oStall}, 1);
    next();
    iLongIssue = 1; iLongIssueAddr = 7; #1;
    check("stall_r7_write_cycle", {31'b0, oStall}, 1);
    next();
    iLongIssue = 0; #1;
    check("no_stall_after_clear", {31'b0, oStall}, 0);
    check("idle_after_clear",     {31'b0, oBusy},  0);
    idle();
    repeat (2) next();

    // r9 long result deferred by three pipeline writes.
    iLongIssue = 1; iLongIssueAddr = 9;
    next();
    idle();
    iLongValid = 1; iLongAddr = 9; iLongData = 32'h1234;
    iPipeWriteEn = 1; iPipeWriteAddr = 1; iPipeWriteData = 32'h11;
    expect_write(cyc + 1, 1, 32'h11);
    next();
    iLongValid = 0; iPipeWriteAddr = 2; iPipeWriteData = 32'h22;
    expect_write(cyc + 1, 2, 32'h22);
    next();
    iPipeWriteAddr = 3; iPipeWriteData = 32'h33;
    expect_write(cyc + 1, 3, 32'h33);
    expect_write(cyc + 2, 9, 32'h1234);
    next();
    idle(); #1;
    check("busy_r9_queued", {31'b0, oBusy}, 1);
    next(); #1;
    check("busy_r9_write_cycle", {31'b0, oBusy}, 1);
    next(); #1;
    check("busy_falls_after_r9", {31'b0, oBusy}, 0);
    repeat (2) next();

    // Three results into a 2-deep FIFO while the pipeline holds the port.
    iPipeWriteEn = 1; iPipeWriteAddr = 10; iPipeWriteData = 32'h100;
    iLongValid = 1; iLongAddr = 20; iLongData = 32'hA0;
    expect_write(cyc + 1, 10, 32'h100);
    #1; check("ready_occ0", {31'b0, oLongReady}, 1);
    next();
    iPipeWriteData = 32'h101; iLongAddr = 21; iLongData = 32'hA1;
    expect_write(cyc + 1, 10, 32'h101);
    #1; check("ready_occ1", {31'b0, oLongReady}, 1);
    next();
    iPipeWriteData = 32'h102; iLongAddr = 22; iLongData = 32'hA2;
    expect_write(cyc + 1, 10, 32'h102);
    expect_write(cyc + 2, 20, 32'hA0);
    expect_write(cyc + 3, 21, 32'hA1);
    expect_write(cyc + 4, 22, 32'hA2);
    #1; check("ready_low_full", {31'b0, oLongReady}, 0);
    next();
    iPipeWriteEn = 0; #1;
    check("ready_low_full_dequeue", {31'b0, oLongReady}, 0);
    next(); #1;
    check("ready_after_drain", {31'b0, oLongReady}, 1);
    next();
    idle();
    repeat (4) next();

    // Head starvation: pipeline busy for 10 cycles with one result waiting.
    iPipeWriteEn = 1; iPipeWriteAddr = 11;
    iLongValid = 1; iLongAddr = 12; iLongData = 32'hC0;
    for (int i = 0; i < 10; i++) begin
      iPipeWriteData = 32'h200 + i;
      expect_write(cyc + 1, 11, 32'h200 + i);
      if (i == 9) expect_write(cyc + 2, 12, 32'hC0);
      #1;
      if (i == 8) check("stall_before_limit", {31'b0, oStall}, 0);
      if (i == 9) check("stall_at_limit", {31'b0, oStall}, {31'b0, STARVE_ON});
      next();
      iLongValid = 0;
    end
    iPipeWriteEn = 0; #1;
    check("stall_dequeue_cycle", {31'b0, oStall}, {31'b0, STARVE_ON});
    next(); #1;
    check("stall_after_dequeue", {31'b0, oStall}, 0);
    idle();
    repeat (2) next();

    // Reset with two queued results and r3 pending.
    iLongIssue = 1; iLongIssueAddr = 3;
    next();
    idle();
    iPipeWriteEn = 1; iPipeWriteAddr = 1; iPipeWriteData = 32'h301;
    iLongValid = 1; iLongAddr = 3; iLongData = 32'h33;
    expect_write(cyc + 1, 1, 32'h301);
    next();
    iPipeWriteData = 32'h302; iLongAddr = 4; iLongData = 32'h44;
    next();
    idle(); #1;
    check("ready_low_before_reset", {31'b0, oLongReady}, 0);
    check("busy_before_reset",      {31'b0, oBusy},      1);
    iSrc0En = 1; iSrc0Addr = 3;
    iRst = 1; #1;
    check("midrst_wen",   {31'b0, oWriteEn},   0);
    check("midrst_waddr", {27'b0, oWriteAddr}, 0);
    check("midrst_wdata", oWriteData,          0);
    check("midrst_stall", {31'b0, oStall},     0);
    check("midrst_busy",  {31'b0, oBusy},      0);
    check("midrst_ready", {31'b0, oLongReady}, 0);
    next();
    iRst = 0;
    next(); #1;
    check("ready_after_midrst",  {31'b0, oLongReady}, 1);
    check("r3_no_stall_after_rst", {31'b0, oStall},   0);
    idle();
    repeat (4) next();
    check("not_busy_at_end", {31'b0, oBusy}, 0);
    check("exp_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Owns the single register-file write port and the decode-stage interlock for long-latency results. It merges in-order pipeline writebacks with out-of-order results from the MDU/FPU/NPU-dequeue path, buffers the latter in a small FIFO, and keeps a per-register pending scoreboard. Decode uses the scoreboard to stall on RAW/WAW hazards. Sits between writeback, the long-latency units, the decode stage, and the register file.

## Interface
- DEPTH, 2, long-result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, cycles the FIFO head may wait before forcing a decode stall (used only with the macro)
- iClk  in  1  clock
- iRst  in  1  reset; asynchronous, active-high
- iPipeWriteEn / iPipeWriteAddr / iPipeWriteData  in  1/5/32  in-order writeback request
- iLongIssue / iLongIssueAddr  in  1/5  decode issuing a long-latency op with this destination
- iLongValid / iLongAddr / iLongData  in  1/5/32  long-latency result offered
- oLongReady  out  1  result accepted when iLongValid & oLongReady
- iSrc0En / iSrc0Addr, iSrc1En / iSrc1Addr, iDestEn / iDestAddr  in  1/5 each  decode operand queries
- oStall  out  1  decode must hold its instruction
- oWriteEn / oWriteAddr / oWriteData  out  1/5/32  registered register-file write port
- oBusy  out  1  any pending bit set or FIFO non-empty; used for halt drain

## Operation
- Scoreboard: 32 pending bits; bit 0 is hard-wired 0.
  - Set at the edge where iLongIssue & !oStall & addr≠0.
  - Cleared at the edge ending the cycle in which a long result for that address drives oWriteEn.
- oStall (combinational) = hazard | starve.
  - hazard = (iSrc0En & pending[iSrc0Addr]) | (iSrc1En & pending[iSrc1Addr]) | (iDestEn & pending[iDestAddr]).
  - starve is defined under Configuration.
- FIFO:
  - oLongReady = !full.
  - An accepted result is enqueued at the edge.
  - Results addressed to r0 are accepted and discarded (never enqueued).
- Write-port selection each cycle:
  - iPipeWriteEn high (addr≠0): pipeline wins.
  - Otherwise, FIFO not empty: the FIFO head wins and is dequeued.
  - Otherwise: idle.
- Pipeline writes to r0 are dropped and do not consume the port.
- A long result whose address is not pending is still written (bench flags it as a protocol error).

## Timing
- Reset (async assert) values:
  - pending = 0, FIFO empty, oWriteEn = 0, oWriteAddr = 0, oWriteData = 0.
  - oStall = 0, oBusy = 0, oLongReady = 0.
  - oLongReady returns to 1 in the first cycle after iRst deasserts.
- Pipeline write latency: request in cycle N → oWriteEn in N+1.
- Long result latency:
  - Accepted in cycle N → earliest oWriteEn in N+2.
  - Deferred one cycle for every cycle iPipeWriteEn is high.
- Pending clears at the end of the oWriteEn cycle, so decode stalls through that cycle and reads the register at N+3 at the earliest.
- Simultaneous events:
  - Issue to an address whose clear happens the same cycle: the hazard still stalls; no set occurs.
  - Enqueue while full: impossible (ready low).
  - Enqueue and dequeue in the same cycle while full: ready stays low that cycle.
  - Enqueue and dequeue when not full: occupancy unchanged.
- Reset mid-operation discards FIFO contents and all pending bits. Upstream units are reset by the same iRst.

## Configuration
- REGFILE_ARB_STARVE_EN defined:
  - A counter tracks consecutive cycles the FIFO head is non-empty and not dequeued.
  - When the counter reaches STARVE_LIMIT, starve = 1 and oStall is forced high until the head dequeues.
  - The counter resets on every dequeue and on empty.
- Undefined: starve = 0, no counter is built, and STARVE_LIMIT is ignored.

## Structure
- Shared package regfile_arb_pkg holds:
  - REG_ADDR_W = 5, REG_DATA_W = 32, REG_COUNT = 32.
  - A packed write-request typedef {addr, data}.
- One sub-module, regfile_arb_fifo: parameterised DEPTH synchronous FIFO with full/empty, async active-high reset, holding the write-request type.

## Test plan
- Pipeline write r5 = 0x0000_00AA in cycle 3 → oWriteEn = 1, oWriteAddr = 5, oWriteData = 0xAA in cycle 4; a pipeline write to r0 produces no oWriteEn.
- Issue long op to r7, then decode reads r7 (iSrc0En) → oStall = 1 until the cycle after r7's oWriteEn; a different register read shows no stall.
- Long result r9 = 0x1234 accepted while iPipeWriteEn is held high 3 cycles → pipeline writes go first; r9 is written in the first idle cycle; oBusy falls afterwards.
- Offer 3 results with DEPTH = 2 and pipeline writes continuous → oLongReady low after 2 accepts; the third is accepted the cycle after the first drain.
- With REGFILE_ARB_STARVE_EN, STARVE_LIMIT = 8, pipeline busy continuously → oStall rises after 8 waiting cycles and drops the cycle after dequeue; without the macro, oStall stays 0.
- Assert iRst with 2 FIFO entries and r3 pending → all outputs 0 immediately; after release oLongReady = 1, and reading r3 does not stall.
